// File: rtl/ladybird_program_loader_pkg.sv
// Shared definitions for the Ladybird UART program loader: FSM states, response bytes, bus width.
package ladybird_config;

  localparam int XLEN = 32;

  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT0,
    ST_CNT1,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_RESP
  } loader_state_e;

  // States in which a host byte may be taken from the serial interface.
  function automatic logic rx_open(input loader_state_e s);
    return s inside {ST_IDLE, ST_CNT0, ST_CNT1, ST_DATA, ST_CSUM};
  endfunction

  // States in which silence from the host counts towards the inter-byte timeout.
  function automatic logic rx_timed(input loader_state_e s);
    return s inside {ST_CNT0, ST_CNT1, ST_DATA, ST_CSUM};
  endfunction

endpackage

// File: rtl/ladybird_bus.sv
// Ladybird system bus: a primary raises req with addr/wstrb/data and holds them until gnt.
interface ladybird_bus #(
  parameter int XLEN = 32
);
  logic              req;
  logic [31:0]       addr;
  logic [XLEN/8-1:0] wstrb;
  logic [XLEN-1:0]   data;
  logic              gnt;

  modport primary (output req, output addr, output wstrb, output data, input gnt);
  modport secondary (input req, input addr, input wstrb, input data, output gnt);
endinterface

// File: rtl/ladybird_program_loader_word_assembler.sv
// Byte-to-word shifter for the loader: bytes arrive LSB first, word_valid holds until word_ack.
module ladybird_loader_word_assembler
  import ladybird_config::*;
(
  input  logic            clk,
  input  logic            anrst,
  input  logic            i_clear,
  input  logic [7:0]      i_byte,
  input  logic            i_byte_vld,
  input  logic            i_word_ack,
  output logic [XLEN-1:0] o_word,
  output logic            o_word_valid,
  output logic            o_last_byte
);

  localparam int NBYTES = XLEN / 8;
  localparam int IDX_W  = $clog2(NBYTES);

  logic [XLEN-1:0]  r_word;
  logic [IDX_W-1:0] r_idx;
  logic             r_word_valid;
  logic             w_last;

  assign w_last = (r_idx == IDX_W'(NBYTES - 1));

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      r_word       <= '0;
      r_idx        <= '0;
      r_word_valid <= 1'b0;
    end else if (i_clear) begin
      r_idx        <= '0;
      r_word_valid <= 1'b0;
    end else if (i_byte_vld) begin
      // Shift right so the first byte received ends up in the least significant lane.
      r_word <= {i_byte, r_word[XLEN-1:8]};
      r_idx  <= r_idx + 1'b1;
      if (w_last) r_word_valid <= 1'b1;
    end else if (i_word_ack) begin
      r_word_valid <= 1'b0;
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;
  assign o_last_byte  = w_last;

endmodule

// File: rtl/ladybird_program_loader.sv
// UART boot loader: frames host bytes into words, writes them to instruction RAM, answers ACK/NAK.
// Optional checksum byte at frame end is enabled by defining LADYBIRD_LOADER_CHECKSUM_EN.
module ladybird_program_loader
  import ladybird_config::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MAX_WORDS = 1024,
  parameter logic [7:0]  SYNC_BYTE = 8'h55,
  parameter int          TIMEOUT   = 100000
) (
  input  logic             clk,
  input  logic             anrst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  ladybird_bus.primary     bus,
  output logic             core_run,
  output logic             busy
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  loader_state_e     r_state, w_next;
  logic              r_rx_ready, r_tx_valid, r_core_run, r_busy, r_req, r_resp_ack;
  logic [7:0]        r_tx_data;
  logic [15:0]       r_cnt, r_idx;
  logic [TMO_W-1:0]  r_tmo;
  logic [31:0]       r_addr;
  logic [XLEN/8-1:0] r_wstrb;
`ifdef LADYBIRD_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic              w_acc, w_sync, w_gnt_edge, w_tmo, w_last_word, w_resp_ack, w_resp_done;
  logic [15:0]       w_cnt_full;
  logic [XLEN-1:0]   w_word;
  logic              w_word_valid, w_last_byte, w_payload_byte;

  assign w_acc          = rx_valid && r_rx_ready;
  assign w_sync         = (r_state == ST_IDLE) && w_acc && (rx_data == SYNC_BYTE);
  assign w_payload_byte = (r_state == ST_DATA) && w_acc;
  assign w_gnt_edge     = r_req && bus.gnt && w_word_valid;
  assign w_tmo          = rx_timed(r_state) && !w_acc && (r_tmo == TMO_W'(TIMEOUT - 1));
  assign w_cnt_full     = {rx_data, r_cnt[7:0]};
  assign w_last_word    = (r_idx == r_cnt - 16'd1);
  assign w_resp_done    = (r_state == ST_RESP) && r_tx_valid && tx_ready;

  ladybird_loader_word_assembler u_asm (
    .clk          (clk),
    .anrst        (anrst),
    .i_clear      (w_sync),
    .i_byte       (rx_data),
    .i_byte_vld   (w_payload_byte),
    .i_word_ack   (w_gnt_edge),
    .o_word       (w_word),
    .o_word_valid (w_word_valid),
    .o_last_byte  (w_last_byte)
  );

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_resp_ack = 1'b0;
    case (r_state)
      ST_IDLE: if (w_sync) w_next = ST_CNT0;
      ST_CNT0: begin
        if (w_acc)      w_next = ST_CNT1;
        else if (w_tmo) w_next = ST_RESP;
      end
      ST_CNT1: begin
        if (w_acc) begin
          if (w_cnt_full == 16'd0) begin
            w_next     = ST_RESP;
            w_resp_ack = 1'b1;
          end else if (int'(w_cnt_full) > MAX_WORDS) begin
            w_next = ST_RESP;
          end else begin
            w_next = ST_DATA;
          end
        end else if (w_tmo) begin
          w_next = ST_RESP;
        end
      end
      ST_DATA: begin
        if (w_acc && w_last_byte) w_next = ST_WRITE;
        else if (w_tmo)           w_next = ST_RESP;
      end
      ST_WRITE: begin
        if (w_gnt_edge) begin
          if (!w_last_word) begin
            w_next = ST_DATA;
          end else begin
`ifdef LADYBIRD_LOADER_CHECKSUM_EN
            w_next = ST_CSUM;
`else
            w_next     = ST_RESP;
            w_resp_ack = 1'b1;
`endif
          end
        end
      end
`ifdef LADYBIRD_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (w_acc) begin
          w_next     = ST_RESP;
          w_resp_ack = (rx_data == r_csum);
        end else if (w_tmo) begin
          w_next = ST_RESP;
        end
      end
`endif
      ST_RESP: if (w_resp_done) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      r_rx_ready <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_wstrb    <= '0;
      r_core_run <= 1'b0;
      r_busy     <= 1'b0;
      r_resp_ack <= 1'b0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_tmo      <= '0;
    end else begin
      r_rx_ready <= rx_open(w_next);
      r_req      <= (w_next == ST_WRITE);
      r_wstrb    <= (w_next == ST_WRITE) ? '1 : '0;
      r_tx_valid <= (w_next == ST_RESP);

      // The address is latched once per word so it cannot move while the bus stalls.
      if (w_next == ST_WRITE && r_state != ST_WRITE)
        r_addr <= BASE_ADDR + {14'd0, r_idx, 2'b00};

      if (w_sync)          r_idx <= '0;
      else if (w_gnt_edge) r_idx <= r_idx + 16'd1;

      if (r_state == ST_CNT0 && w_acc) r_cnt[7:0]  <= rx_data;
      if (r_state == ST_CNT1 && w_acc) r_cnt[15:8] <= rx_data;

      if (rx_timed(r_state) && !w_acc) r_tmo <= r_tmo + 1'b1;
      else                             r_tmo <= '0;

      if (w_next == ST_RESP && r_state != ST_RESP) begin
        r_resp_ack <= w_resp_ack;
        r_tx_data  <= w_resp_ack ? ACK_BYTE : NAK_BYTE;
      end

      if (w_sync) begin
        r_busy     <= 1'b1;
        r_core_run <= 1'b0;
      end else if (w_resp_done) begin
        r_busy     <= 1'b0;
        r_core_run <= r_resp_ack;
      end
    end
  end

`ifdef LADYBIRD_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst)
      r_csum <= '0;
    else if (w_sync)
      r_csum <= '0;
    else if (w_acc && r_state inside {ST_CNT0, ST_CNT1, ST_DATA})
      r_csum <= r_csum ^ rx_data;
  end
`endif

  assign rx_ready  = r_rx_ready;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign core_run  = r_core_run;
  assign busy      = r_busy;
  assign bus.req   = r_req;
  assign bus.addr  = r_addr;
  assign bus.wstrb = r_wstrb;
  assign bus.data  = w_word;

endmodule

// File: tb/tb_ladybird_program_loader.sv
// Self-checking bench for ladybird_program_loader with a bus-write scoreboard and RAM model.
module tb_ladybird_program_loader;
  import ladybird_config::*;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          TMO  = 40;
  localparam logic [7:0]  SYNC = 8'h55;

  logic       clk = 1'b0;
  logic       anrst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b0;
  logic       rx_ready, tx_valid, core_run, busy;
  logic [7:0] tx_data;

  ladybird_bus #(.XLEN(XLEN)) u_bus ();

  ladybird_program_loader #(
    .BASE_ADDR (BASE),
    .MAX_WORDS (1024),
    .SYNC_BYTE (SYNC),
    .TIMEOUT   (TMO)
  ) dut (
    .clk      (clk),
    .anrst    (anrst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .bus      (u_bus),
    .core_run (core_run),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          errors = 0;
  int          checks = 0;
  wr_t         exp_q[$];
  logic [31:0] ram [logic [31:0]];
  logic [31:0] payload [8];
  int          n_writes = 0;
  bit          req_seen = 0;
  int          gnt_mode = 0;   // 0: always grant, 1: random delay, 2: never grant
  int          gnt_dly = 0;
  bit          hold_vld = 0;
  logic [31:0] hold_addr, hold_data;

  // Bus secondary model: decides gnt for the next edge and scores each completed write.
  always @(negedge clk) begin
    logic g;
    wr_t  e;
    if (!anrst) begin
      u_bus.gnt = 1'b0;
      hold_vld  = 0;
    end else begin
      if (u_bus.req) req_seen = 1;
      if (hold_vld && u_bus.req) begin
        checks++;
        if (u_bus.addr !== hold_addr || u_bus.data !== hold_data || u_bus.wstrb !== 4'hF) begin
          errors++;
          $display("FAIL bus_stable: addr=%h data=%h wstrb=%h required addr=%h data=%h wstrb=f",
                   u_bus.addr, u_bus.data, u_bus.wstrb, hold_addr, hold_data);
        end
      end
      g = 1'b0;
      if (gnt_mode == 0) g = 1'b1;
      else if (gnt_mode == 1 && u_bus.req) begin
        if (gnt_dly == 0) g = 1'b1;
        else gnt_dly--;
      end
      u_bus.gnt = g;
      if (u_bus.req && g) begin
        n_writes++;
        ram[u_bus.addr] = u_bus.data;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bus_write_unexpected: addr=%h data=%h required no write", u_bus.addr, u_bus.data);
        end else begin
          e = exp_q.pop_front();
          if (u_bus.addr !== e.addr || u_bus.data !== e.data || u_bus.wstrb !== 4'hF) begin
            errors++;
            $display("FAIL bus_write: addr=%h data=%h wstrb=%h required addr=%h data=%h wstrb=f",
                     u_bus.addr, u_bus.data, u_bus.wstrb, e.addr, e.data);
          end
        end
        hold_vld = 0;
        gnt_dly  = $urandom_range(0, 7);
      end else begin
        hold_vld  = u_bus.req;
        hold_addr = u_bus.addr;
        hold_data = u_bus.data;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    if (n >= 300) begin
      errors++;
      checks++;
      $display("FAIL rx_ready_wait: rx_ready=0 after %0d cycles, required 1", n);
    end
  endtask

  // Sends a header with count cnt followed by nw words from payload[]; queues the expected writes.
  task automatic send_frame(input logic [15:0] cnt, input int nw, input bit corrupt);
    logic [7:0] cs;
    logic [31:0] w;
    cs = cnt[7:0] ^ cnt[15:8];
    send_byte(SYNC);
    send_byte(cnt[7:0]);
    send_byte(cnt[15:8]);
    for (int k = 0; k < nw; k++) begin
      w = payload[k];
      exp_q.push_back('{addr: BASE + 32'(k) * 4, data: w});
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8]);
        cs ^= w[8*b +: 8];
      end
    end
`ifdef LADYBIRD_LOADER_CHECKSUM_EN
    if (cnt != 16'd0 && nw == int'(cnt)) send_byte(corrupt ? ~cs : cs);
`else
    if (corrupt) cs = ~cs;
`endif
  endtask

  task automatic wait_resp(input logic [7:0] exp_byte, input bit exp_run, input string name);
    int n = 0;
    logic [7:0] first;
    while (!tx_valid && n < 600) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!tx_valid) begin
      errors++;
      $display("FAIL %s_resp_timeout: tx_valid=0 after %0d cycles, required 1", name, n);
      return;
    end
    checks++;
    if (tx_data !== exp_byte) begin
      errors++;
      $display("FAIL %s_resp_byte: tx_data=%h required %h", name, tx_data, exp_byte);
    end
    first = tx_data;
    checks++;
    if (core_run !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_resp_pending: core_run=%b busy=%b required core_run=0 busy=1", name, core_run, busy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== first) begin
      errors++;
      $display("FAIL %s_resp_hold: tx_valid=%b tx_data=%h required 1 %h", name, tx_valid, tx_data, first);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || core_run !== exp_run) begin
      errors++;
      $display("FAIL %s_resp_done: tx_valid=%b busy=%b core_run=%b required 0 0 %b",
               name, tx_valid, busy, core_run, exp_run);
    end
  endtask

  task automatic check_ram(input int nw, input string name);
    for (int k = 0; k < nw; k++) begin
      logic [31:0] a;
      a = BASE + 32'(k) * 4;
      checks++;
      if (!ram.exists(a) || ram[a] !== payload[k]) begin
        errors++;
        $display("FAIL %s_ram[%0d]: got %h required %h", name, k, ram.exists(a) ? ram[a] : 32'hx, payload[k]);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending_writes: %0d outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    anrst = 1'b0;
    #23;
    checks++;
    if ({rx_ready, tx_valid, tx_data, u_bus.req, u_bus.addr, u_bus.wstrb, u_bus.data, core_run, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rx_ready=%b tx_valid=%b tx_data=%h req=%b addr=%h wstrb=%h data=%h core_run=%b busy=%b required all 0",
               rx_ready, tx_valid, tx_data, u_bus.req, u_bus.addr, u_bus.wstrb, u_bus.data, core_run, busy);
    end
    @(negedge clk);
    anrst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_ready: rx_ready=%b required 1", rx_ready);
    end
  endtask

  task automatic test_full_grant();
    gnt_mode = 0;
    n_writes = 0;
    ram.delete();
    send_frame(16'd5, 5, 1'b0);
    wait_resp(ACK_BYTE, 1'b1, "full_grant");
    check_ram(5, "full_grant");
    checks++;
    if (n_writes != 5) begin
      errors++;
      $display("FAIL full_grant_writes: %0d required 5", n_writes);
    end
  endtask

  task automatic test_delayed_grant();
    gnt_mode = 1;
    gnt_dly  = $urandom_range(0, 7);
    ram.delete();
    send_frame(16'd5, 5, 1'b0);
    wait_resp(ACK_BYTE, 1'b1, "delayed_grant");
    check_ram(5, "delayed_grant");
    gnt_mode = 0;
  endtask

  task automatic test_garbage_zero();
    req_seen = 0;
    send_byte(8'hAA);
    send_byte(8'h00);
    send_frame(16'd0, 0, 1'b0);
    wait_resp(ACK_BYTE, 1'b1, "zero_count");
    checks++;
    if (req_seen) begin
      errors++;
      $display("FAIL zero_count_bus: req seen=1 required 0");
    end
  endtask

  task automatic test_too_many();
    req_seen = 0;
    send_frame(16'hFFFF, 0, 1'b0);
    wait_resp(NAK_BYTE, 1'b0, "too_many");
    checks++;
    if (req_seen) begin
      errors++;
      $display("FAIL too_many_bus: req seen=1 required 0");
    end
  endtask

  task automatic test_timeout();
    send_byte(SYNC);
    checks++;
    if (busy !== 1'b1 || core_run !== 1'b0) begin
      errors++;
      $display("FAIL timeout_busy: busy=%b core_run=%b required 1 0", busy, core_run);
    end
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    wait_resp(NAK_BYTE, 1'b0, "timeout");
    ram.delete();
    send_frame(16'd2, 2, 1'b0);
    wait_resp(ACK_BYTE, 1'b1, "after_timeout");
    check_ram(2, "after_timeout");
  endtask

`ifdef LADYBIRD_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    ram.delete();
    send_frame(16'd3, 3, 1'b0);
    wait_resp(ACK_BYTE, 1'b1, "csum_good");
    check_ram(3, "csum_good");
    ram.delete();
    send_frame(16'd3, 3, 1'b1);
    wait_resp(NAK_BYTE, 1'b0, "csum_bad");
    check_ram(3, "csum_bad");
  endtask
`endif

  task automatic test_reset_in_write();
    int  n = 0;
    bit  resp_seen = 0;
    gnt_mode = 2;
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h00);
    for (int b = 0; b < 4; b++) send_byte(payload[0][8*b +: 8]);
    while (!u_bus.req && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (u_bus.req !== 1'b1) begin
      errors++;
      $display("FAIL rst_write_req_rise: req=%b required 1", u_bus.req);
    end
    #2 anrst = 1'b0;
    #1;
    checks++;
    if (u_bus.req !== 1'b0 || core_run !== 1'b0 || busy !== 1'b0 || u_bus.wstrb !== 4'h0) begin
      errors++;
      $display("FAIL rst_write_abort: req=%b core_run=%b busy=%b wstrb=%h required 0 0 0 0",
               u_bus.req, core_run, busy, u_bus.wstrb);
    end
    @(negedge clk);
    anrst    = 1'b1;
    gnt_mode = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (tx_valid) resp_seen = 1;
    end
    checks++;
    if (resp_seen) begin
      errors++;
      $display("FAIL rst_write_no_resp: tx_valid seen=1 required 0");
    end
  endtask

  initial begin
    payload[0] = 32'h0403_0201;
    payload[1] = 32'h5555_5555;
    payload[2] = 32'hDEAD_BEEF;
    payload[3] = 32'h0000_0055;
    payload[4] = 32'hA5C3_3C5A;
    for (int k = 5; k < 8; k++) payload[k] = $urandom;

    test_reset();
    test_full_grant();
    test_delayed_grant();
    test_garbage_zero();
    test_too_many();
    test_timeout();
`ifdef LADYBIRD_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_in_write();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
